muldiv_issue_ctrl: RTL and testbench

//  CPU-side initiator for the shared multiply/divide calculator. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO

---
 rtl/muldiv_issue_ctrl_pkg.sv | 34 +++
 rtl/muldiv_op_map.sv | 23 ++
 rtl/muldiv_issue_ctrl.sv | 143 ++++++++++++++
 tb/tb_muldiv_issue_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_issue_ctrl_pkg.sv
// Shared op codes, calculator select codes, FSM states and decoded-op struct
// for the multiply/divide issue controller.
package muldiv_issue_ctrl_pkg;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    CALC_MUL  = 2'd0,
    CALC_MULU = 2'd1,
    CALC_DIV  = 2'd2,
    CALC_DIVU = 2'd3
  } calc_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic      is_arith;
    logic      is_mthi;
    logic      is_mtlo;
    calc_sel_e calc_sel;
  } op_dec_t;

endpackage

// File: rtl/muldiv_op_map.sv
// Combinational decode of an EX-stage op code into arith/MTHI/MTLO flags
// and the calculator select code.
module muldiv_op_map
  import muldiv_issue_ctrl_pkg::*;
(
  input  logic [2:0] op_i,
  output op_dec_t    dec_o
);

  always_comb begin
    dec_o = '0;
    case (op_i)
      OP_MULT:  begin dec_o.is_arith = 1'b1; dec_o.calc_sel = CALC_MUL;  end
      OP_MULTU: begin dec_o.is_arith = 1'b1; dec_o.calc_sel = CALC_MULU; end
      OP_DIV:   begin dec_o.is_arith = 1'b1; dec_o.calc_sel = CALC_DIV;  end
      OP_DIVU:  begin dec_o.is_arith = 1'b1; dec_o.calc_sel = CALC_DIVU; end
      OP_MTHI:  dec_o.is_mthi = 1'b1;
      OP_MTLO:  dec_o.is_mtlo = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: rtl/muldiv_issue_ctrl.sv
// Requester side of the mul/div calculator handshake: issues ops, stalls EX until
// finish, owns HI/LO. Optional WAIT watchdog enabled by MULDIV_TIMEOUT_EN.
module muldiv_issue_ctrl
  import muldiv_issue_ctrl_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             hilo_rd,
  output logic             stall_o,
  output logic             busy_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             calc_ena_o,
  output logic [1:0]       calc_sel_o,
  output logic [WIDTH-1:0] calc_a_o,
  output logic [WIDTH-1:0] calc_b_o,
  input  logic             calc_finish_i,
  input  logic [WIDTH-1:0] calc_hi_i,
  input  logic [WIDTH-1:0] calc_lo_i,
  output logic             err_o
);

  state_e           state_q, state_d;
  logic             seen_low_q, seen_low_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [1:0]       sel_q, sel_d;
  op_dec_t          dec;
  logic             accept;
  logic             timeout;

  muldiv_op_map u_op_map (
    .op_i  (op),
    .dec_o (dec)
  );

  // Finish is a level; only a rising level seen after a low is our own result.
  assign accept = (state_q == ST_WAIT) && calc_finish_i && seen_low_q;

`ifdef MULDIV_TIMEOUT_EN
  logic [CNT_W-1:0] wdog_q, wdog_d;

  assign wdog_d  = (state_q == ST_WAIT) ? wdog_q + CNT_W'(1) : '0;
  assign timeout = (state_q == ST_WAIT) && !accept &&
                   (wdog_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wdog_q <= '0;
    else     wdog_q <= wdog_d;
  end
`else
  logic unused_cfg;
  assign timeout    = 1'b0;
  assign unused_cfg = ^{TIMEOUT_CYCLES, CNT_W};
`endif

  // MFHI/MFLO read hi_o/lo_o directly; the read strobe needs no handling here.
  logic unused_hilo_rd;
  assign unused_hilo_rd = hilo_rd;

  always_comb begin
    state_d    = state_q;
    seen_low_d = seen_low_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    a_d        = a_q;
    b_d        = b_q;
    sel_d      = sel_q;
    case (state_q)
      ST_IDLE: begin
        if (op_valid) begin
          if (dec.is_arith) begin
            a_d     = rs_val;
            b_d     = rt_val;
            sel_d   = dec.calc_sel;
            state_d = ST_ISSUE;
          end else if (dec.is_mthi) begin
            hi_d = rs_val;
          end else if (dec.is_mtlo) begin
            lo_d = rs_val;
          end
        end
      end
      ST_ISSUE: begin
        seen_low_d = 1'b0;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (!calc_finish_i) seen_low_d = 1'b1;
        if (accept) begin
          hi_d    = calc_hi_i;
          lo_d    = calc_lo_i;
          state_d = ST_DONE;
        end else if (timeout) begin
          state_d = ST_IDLE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      seen_low_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      sel_q      <= '0;
    end else begin
      state_q    <= state_d;
      seen_low_q <= seen_low_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sel_q      <= sel_d;
    end
  end

  // Stall on the issuing cycle itself so EX holds the instruction.
  assign stall_o    = (state_q == ST_ISSUE) || (state_q == ST_WAIT) ||
                      ((state_q == ST_IDLE) && op_valid && dec.is_arith);
  assign busy_o     = (state_q != ST_IDLE);
  assign calc_ena_o = (state_q == ST_ISSUE);
  assign calc_sel_o = sel_q;
  assign calc_a_o   = a_q;
  assign calc_b_o   = b_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;
  assign err_o      = timeout;

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Directed bench for muldiv_issue_ctrl; the bench plays the calculator and
// scoreboards expected HI/LO per issued op.
module tb_muldiv_issue_ctrl;
  import muldiv_issue_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        hilo_rd;
  logic        stall_o, busy_o, calc_ena_o, err_o;
  logic [31:0] hi_o, lo_o, calc_a_o, calc_b_o;
  logic [1:0]  calc_sel_o;
  logic        calc_finish_i;
  logic [31:0] calc_hi_i, calc_lo_i;

  int tests = 0;
  int failed = 0;
  int ena_pulses = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  muldiv_issue_ctrl #(.WIDTH(32), .TIMEOUT_CYCLES(64), .CNT_W(7)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .rs_val(rs_val),
    .rt_val(rt_val), .hilo_rd(hilo_rd), .stall_o(stall_o), .busy_o(busy_o),
    .hi_o(hi_o), .lo_o(lo_o), .calc_ena_o(calc_ena_o), .calc_sel_o(calc_sel_o),
    .calc_a_o(calc_a_o), .calc_b_o(calc_b_o), .calc_finish_i(calc_finish_i),
    .calc_hi_i(calc_hi_i), .calc_lo_i(calc_lo_i), .err_o(err_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic [31:0] q, r;
    sa = a;
    sb = b;
    model = '0;
    case (o)
      OP_MULT:  model = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      OP_MULTU: model = {32'd0, a} * {32'd0, b};
      OP_DIV:   begin q = sa / sb; r = sa % sb; model = {r, q}; end
      OP_DIVU:  begin q = a / b;   r = a % b;   model = {r, q}; end
      default:  model = '0;
    endcase
  endfunction

  function automatic logic [1:0] exp_sel(input logic [2:0] o);
    case (o)
      OP_MULT:  exp_sel = 2'd0;
      OP_MULTU: exp_sel = 2'd1;
      OP_DIV:   exp_sel = 2'd2;
      default:  exp_sel = 2'd3;
    endcase
  endfunction

  // Present an arith op in IDLE and play the calculator: finish stays high
  // (stale) for `stale` WAIT cycles, low for `lat`, then high with the result.
  // Returns with the DUT in DONE and op_valid still asserted.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int stale, input int lat);
    logic [63:0] res, exp;
    int done_k, stall_bad, extra_ena;
    res = model(o, a, b);
    exp_q.push_back(res);
    op_valid = 1'b1; op = o; rs_val = a; rt_val = b;
    #1;
    check({tag, "_issue_stall"}, stall_o, 1);
    step();
    ena_pulses += int'(calc_ena_o);
    check({tag, "_ena"}, calc_ena_o, 1);
    check({tag, "_sel"}, calc_sel_o, exp_sel(o));
    check({tag, "_a"}, calc_a_o, a);
    check({tag, "_b"}, calc_b_o, b);
    calc_finish_i = (stale > 0);
    step();
    done_k = -1; stall_bad = 0; extra_ena = 0;
    for (int k = 1; k < 200; k++) begin
      if (busy_o && !stall_o) begin done_k = k; break; end
      if (!stall_o) stall_bad++;
      if (calc_ena_o) extra_ena++;
      if (k <= stale) calc_finish_i = 1'b1;
      else if (k <= stale + lat) calc_finish_i = 1'b0;
      else begin
        calc_finish_i = 1'b1;
        {calc_hi_i, calc_lo_i} = res;
      end
      step();
    end
    ena_pulses += extra_ena;
    check({tag, "_done_cycle"}, done_k, stale + lat + 2);
    check({tag, "_wait_stall"}, stall_bad, 0);
    check({tag, "_single_ena"}, extra_ena, 0);
    exp = exp_q.pop_front();
    check({tag, "_hi"}, hi_o, exp[63:32]);
    check({tag, "_lo"}, lo_o, exp[31:0]);
  endtask

  initial begin
    logic [63:0] saved;
    int errk, stall_low, err_seen, ena_before;
    rst = 1'b1; op_valid = 1'b0; op = OP_NOP; rs_val = '0; rt_val = '0;
    hilo_rd = 1'b0; calc_finish_i = 1'b0; calc_hi_i = '0; calc_lo_i = '0;
    #1;
    check("rst_hi", hi_o, 0);
    check("rst_lo", lo_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_ena", calc_ena_o, 0);
    check("rst_sel_a_b", {calc_sel_o, calc_a_o, calc_b_o}, 0);
    check("rst_err_stall", {err_o, stall_o}, 0);
    step(); step();
    rst = 1'b0;
    step();

    // 1: signed multiply, finish after 5 cycles
    run_op("mult", OP_MULT, 32'hFFFF_FFFE, 32'd3, 0, 4);
    check("mult_hi_const", hi_o, 32'hFFFF_FFFF);
    check("mult_lo_const", lo_o, 32'hFFFF_FFFA);
    op_valid = 1'b0;
    step();
    check("mult_idle_busy", busy_o, 0);
    check("mult_idle_stall", stall_o, 0);

    // 2: DIVU then MTHI/MTLO in IDLE
    run_op("divu", OP_DIVU, 32'd100, 32'd7, 0, 2);
    check("divu_lo_const", lo_o, 14);
    check("divu_hi_const", hi_o, 2);
    op_valid = 1'b0;
    step();
    hilo_rd = 1'b1;
    op_valid = 1'b1; op = OP_MTHI; rs_val = 32'h55;
    #1;
    check("mthi_stall", stall_o, 0);
    step();
    check("mthi_hi", hi_o, 32'h55);
    check("mthi_lo_kept", lo_o, 14);
    check("mthi_busy", busy_o, 0);
    op = OP_MTLO; rs_val = 32'hAA;
    #1;
    check("mtlo_stall", stall_o, 0);
    step();
    check("mtlo_lo", lo_o, 32'hAA);
    check("mtlo_hi_kept", hi_o, 32'h55);
    op_valid = 1'b0; hilo_rd = 1'b0;
    step();

    // 3: stale finish held high through ISSUE and first WAIT cycle
    run_op("stale", OP_MULT, 32'd7, 32'hFFFF_FFFD, 1, 2);
    op_valid = 1'b0;
    step();

    // 6: back-to-back MULTU then DIV; DIV first shows up in DONE and is ignored
    ena_before = ena_pulses;
    calc_finish_i = 1'b0;
    run_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1);
    op = OP_DIV; rs_val = 32'hFFFF_FF9C; rt_val = 32'd7;
    step();
    check("done_op_ignored_busy", busy_o, 0);
    check("done_op_represent_stall", stall_o, 1);
    run_op("div", OP_DIV, 32'hFFFF_FF9C, 32'd7, 0, 1);
    check("b2b_ena_pulses", ena_pulses - ena_before, 2);
    op_valid = 1'b0;
    step();
    check("b2b_final_lo", lo_o, 32'hFFFF_FFF2);
    check("b2b_final_hi", hi_o, 32'hFFFF_FFFE);

    // 4: reset during WAIT, late finish after release
    calc_finish_i = 1'b0;
    op_valid = 1'b1; op = OP_MULT; rs_val = 32'd5; rt_val = 32'd6;
    step();
    op_valid = 1'b0;
    step(); step();
    check("rstmid_pre_busy", busy_o, 1);
    #2;
    rst = 1'b1;
    #1;
    check("rstmid_busy", busy_o, 0);
    check("rstmid_hilo", {hi_o, lo_o}, 0);
    check("rstmid_ena_stall", {calc_ena_o, stall_o}, 0);
    step();
    rst = 1'b0;
    step(); step();
    calc_finish_i = 1'b1; calc_hi_i = 32'h1234; calc_lo_i = 32'h5678;
    step(); step();
    check("rstmid_late_busy", busy_o, 0);
    check("rstmid_late_hilo", {hi_o, lo_o}, 0);

    // 5: finish never arrives
    calc_finish_i = 1'b0;
    op_valid = 1'b1; op = OP_MTLO; rs_val = 32'hBEEF;
    step();
    op = OP_MULTU; rs_val = 32'd9; rt_val = 32'd9;
    step();
    op_valid = 1'b0;
    saved = {hi_o, lo_o};
    step();
`ifdef MULDIV_TIMEOUT_EN
    errk = -1;
    for (int k = 1; k < 200; k++) begin
      if (err_o) begin errk = k; break; end
      step();
    end
    check("wdog_cycle", errk, 64);
    check("wdog_hilo_kept", {hi_o, lo_o}, saved);
    step();
    check("wdog_err_pulse", err_o, 0);
    check("wdog_stall_drop", stall_o, 0);
    check("wdog_busy_drop", busy_o, 0);
`else
    stall_low = 0; err_seen = 0; errk = 0;
    for (int k = 1; k < 100; k++) begin
      if (!stall_o) stall_low++;
      if (err_o) err_seen++;
      step();
    end
    check("nowdog_stall_held", stall_low, 0);
    check("nowdog_err", err_seen, errk);
    check("nowdog_busy", busy_o, 1);
    check("nowdog_hilo_kept", {hi_o, lo_o}, saved);
    rst = 1'b1;
    step();
    rst = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
